wrr_sp_arbiter: RTL

- Parametrised N-port packet-word arbiter feeding the SRAM controller write path.
- Selects one requesting port per cycle:
  - strict priority (SP) when mode=0;
  - weighted round-robin (WRR) when mode=1.
- Transfers the winning word into a registered output stage.
- valid/ready handshake on every input port and on the output.

---
 rtl/arbiter_pkg.sv | 17 +
 rtl/arb_rr_pick.sv | 28 ++
 rtl/wrr_sp_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the packet-word arbiter (wrr_sp_arbiter).
package arbiter_pkg;
  localparam logic MODE_SP  = 1'b0;
  localparam logic MODE_WRR = 1'b1;

  localparam int DATA_W    = 256;
  localparam int NUM_PORTS = 16;
  localparam int WEIGHT_W  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority encoder: first set req bit at or above start, wrapping to 0.
module arb_rr_pick #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    int p;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      if (!found && req[p]) begin
        found    = 1'b1;
        idx      = IW'(p);
        grant[p] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wrr_sp_arbiter.sv
// N-port strict-priority / weighted round-robin word arbiter with a registered output.
// Optional SP anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module wrr_sp_arbiter #(
  parameter int DATA_W       = arbiter_pkg::DATA_W,
  parameter int NUM_PORTS    = arbiter_pkg::NUM_PORTS,
  parameter int WEIGHT_W     = arbiter_pkg::WEIGHT_W,
  parameter int PORT_W       = arbiter_pkg::clog2(NUM_PORTS),
  parameter int STARVE_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sp0_wrr1,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [PORT_W-1:0]             out_port
);
  import arbiter_pkg::*;

  logic [PORT_W-1:0]    ptr, start, pick_idx, pick_nxt, ptr_nxt;
  logic [WEIGHT_W-1:0]  credit, rem, pick_w;
  logic [NUM_PORTS-1:0] wnz, sp_req, elig, pick_oh;
  logic                 hold, mode_q, hold_eff, found, free, xfer;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wnz
    assign wnz[i] = |weight[i*WEIGHT_W +: WEIGHT_W];
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = clog2(STARVE_LIMIT + 1);
  logic [NUM_PORTS-1:0] starved;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_starve
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
      if (!rst)                                                  cnt <= '0;
      else if (sp0_wrr1 == MODE_WRR || !in_valid[i] || in_ready[i]) cnt <= '0;
      else if (cnt != CNT_W'(STARVE_LIMIT))                      cnt <= cnt + 1'b1;
    assign starved[i] = in_valid[i] && (cnt == CNT_W'(STARVE_LIMIT));
  end

  // Starved ports preempt everyone; among them the lowest index still wins.
  assign sp_req = (|starved) ? starved : in_valid;
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign sp_req = in_valid;
`endif

  assign elig  = (sp0_wrr1 == MODE_WRR) ? (in_valid & wnz) : sp_req;
  assign start = (sp0_wrr1 == MODE_WRR) ? ptr : '0;

  arb_rr_pick #(.N(NUM_PORTS), .IW(PORT_W)) u_pick (
    .req   (elig),
    .start (start),
    .grant (pick_oh),
    .idx   (pick_idx),
    .found (found)
  );

  assign free     = !out_valid || out_ready;
  assign in_ready = (rst && free && found) ? pick_oh : '0;
  assign xfer     = |in_ready;

  // A burst only carries over if WRR was already active last cycle.
  assign hold_eff = hold && (mode_q == MODE_WRR);
  assign pick_w   = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
  assign rem      = (hold_eff && pick_idx == ptr) ? credit - 1'b1 : pick_w - 1'b1;
  assign pick_nxt = (pick_idx == PORT_W'(NUM_PORTS-1)) ? '0 : pick_idx + 1'b1;
  assign ptr_nxt  = (ptr == PORT_W'(NUM_PORTS-1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
      ptr       <= '0;
      credit    <= '0;
      hold      <= 1'b0;
      mode_q    <= MODE_SP;
    end else begin
      mode_q <= sp0_wrr1;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[pick_idx*DATA_W +: DATA_W];
        out_port  <= pick_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (sp0_wrr1 == MODE_WRR) begin
        if (xfer) begin
          if (rem == '0) begin
            ptr    <= pick_nxt;
            credit <= '0;
            hold   <= 1'b0;
          end else begin
            ptr    <= pick_idx;
            credit <= rem;
            hold   <= 1'b1;
          end
        end else if (hold_eff && !in_valid[ptr]) begin
          ptr    <= ptr_nxt;
          credit <= '0;
          hold   <= 1'b0;
        end else if (!hold_eff) begin
          credit <= '0;
          hold   <= 1'b0;
        end
      end
    end
  end
endmodule
